// File: rtl/rs_stream_pkg.sv
// Shared definitions for the RS streaming datapath: code dimensions, frame sizing and
// the parallel-to-serial FSM state type.
package rs_stream_pkg;

  localparam int RS_N            = 200;
  localparam int RS_K            = 168;
  localparam int RS_SYMBOL_WIDTH = 8;

  typedef enum logic {
    P2S_IDLE,
    P2S_SHIFT
  } p2s_state_t;

  // mode = 1 selects encode (whole codeword), mode = 0 selects decode (information part only)
  function automatic int frame_bits(input bit mode, input int n, input int k, input int w);
    return mode ? n * w : k * w;
  endfunction

endpackage

// File: rtl/rs_frame_fifo.sv
// Frame-wide FIFO between the RS wrapper and the serialiser; written on the parallel
// side, popped by the serialiser FSM when it loads its shift register.
module rs_frame_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doWrite;
  logic             doRead;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rdPtr_q];
  assign doWrite   = wr_en_i && !full_o;
  assign doRead    = rd_en_i && !empty_o;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doWrite) wrPtr_q <= wrPtr_q + 1'b1;
      if (doRead)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doWrite, doRead})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) mem_q[wrPtr_q] <= wr_data_i;
  end

endmodule

// File: rtl/parallel_to_serial.sv
// Buffers RS frames and re-serialises them LSB-first onto a 1-bit valid/ready stream.
// Optional frame start/last markers are enabled with `P2S_FRAME_MARKER_EN.
module parallel_to_serial
  import rs_stream_pkg::*;
#(
  parameter int N            = RS_N,
  parameter int K            = RS_K,
  parameter int SYMBOL_WIDTH = RS_SYMBOL_WIDTH,
  parameter     MODE         = "ENCODE",
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N*SYMBOL_WIDTH-1:0] parallel_data_in,
  input  logic                      parallel_data_valid,
  output logic                      parallel_data_ready,
  output logic                      serial_data_out,
  output logic                      serial_data_valid,
  input  logic                      serial_data_ready,
`ifdef P2S_FRAME_MARKER_EN
  output logic                      serial_frame_start,
  output logic                      serial_frame_last,
`endif
  output logic                      busy,
  output logic [3:0]                frames_buffered,
  output logic [15:0]               bits_sent,
  output logic [31:0]               underrun_cycles
);

  localparam int FRAME_BITS = frame_bits(MODE == "ENCODE", N, K, SYMBOL_WIDTH);
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  p2s_state_t            state_q;
  logic [FRAME_BITS-1:0] shreg_q;
  logic [15:0]           bitCnt_q;
  logic                  started_q;
  logic [31:0]           underrun_q;
  logic [31:0]           underrun_d;

  logic [FRAME_BITS-1:0] fifoRdData;
  logic [CW-1:0]         fifoCount;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  fifoPop;
  logic                  serialValid;
  logic                  lastBit;
  logic                  unusedInputBits;

  // In decode mode the parity symbols above FRAME_BITS are never stored.
  assign unusedInputBits = ^parallel_data_in;

  rs_frame_fifo #(
    .WIDTH (FRAME_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (parallel_data_valid),
    .wr_data_i (parallel_data_in[FRAME_BITS-1:0]),
    .rd_en_i   (fifoPop),
    .rd_data_o (fifoRdData),
    .count_o   (fifoCount),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty)
  );

  assign serialValid = (state_q == P2S_SHIFT);
  assign lastBit     = (bitCnt_q == 16'(FRAME_BITS - 1));
  assign fifoPop     = (state_q == P2S_IDLE) ||
                       (serialValid && serial_data_ready && lastBit);

  assign parallel_data_ready = !fifoFull;
  assign serial_data_valid   = serialValid;
  assign serial_data_out     = serialValid & shreg_q[0];
  assign busy                = serialValid || !fifoEmpty;
  assign frames_buffered     = 4'(fifoCount);
  assign bits_sent           = bitCnt_q;
  assign underrun_cycles     = underrun_q;

`ifdef P2S_FRAME_MARKER_EN
  assign serial_frame_start = serialValid && (bitCnt_q == 16'd0);
  assign serial_frame_last  = serialValid && lastBit;
`endif

  // Reloading on the last accepted bit keeps back-to-back frames gap-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= P2S_IDLE;
      shreg_q  <= '0;
      bitCnt_q <= '0;
    end else begin
      case (state_q)
        P2S_IDLE: begin
          if (!fifoEmpty) begin
            shreg_q  <= fifoRdData;
            bitCnt_q <= '0;
            state_q  <= P2S_SHIFT;
          end
        end
        P2S_SHIFT: begin
          if (serial_data_ready) begin
            if (lastBit) begin
              bitCnt_q <= '0;
              if (!fifoEmpty) begin
                shreg_q <= fifoRdData;
              end else begin
                shreg_q <= '0;
                state_q <= P2S_IDLE;
              end
            end else begin
              shreg_q  <= shreg_q >> 1;
              bitCnt_q <= bitCnt_q + 16'd1;
            end
          end
        end
        default: state_q <= P2S_IDLE;
      endcase
    end
  end

  always_comb begin
    underrun_d = underrun_q;
    if (started_q && serial_data_ready && !serialValid && (underrun_q != 32'hFFFF_FFFF))
      underrun_d = underrun_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      started_q  <= 1'b0;
      underrun_q <= '0;
    end else begin
      started_q  <= started_q | serialValid;
      underrun_q <= underrun_d;
    end
  end

endmodule
